proc_run_monitor: RTL and testbench

Parametrised run controller and result checker for the processor core, the synthesizable successor to the core's stimulus bench. It sequences the core's reset, counts execution cycles, watches for halt or timeout, and compares the final flag vector against an expected pattern. It produces a sticky pass/fail/timeout verdict for LEDs or a host interface. It sits between the board-level start/abort controls and the processor's `rst`/`RFlags`/halt signals.

---
 rtl/proc_run_monitor_pkg.sv | 16 +
 rtl/proc_run_monitor_if.sv | 27 ++
 rtl/proc_run_monitor_sat_counter.sv | 20 ++
 rtl/proc_run_monitor.sv | 78 +++++++
 tb/tb_proc_run_monitor.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/proc_run_monitor_pkg.sv
// proc_mon_pkg: run-monitor state encoding and verdict constants.
package proc_mon_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;
    // Verdict bits packed as {timeout, fail, pass}.
    typedef logic [2:0] verdict_t;
    localparam verdict_t V_NONE    = 3'b000;
    localparam verdict_t V_PASS    = 3'b001;
    localparam verdict_t V_FAIL    = 3'b010;
    localparam verdict_t V_TIMEOUT = 3'b110;
endpackage

// File: rtl/proc_run_monitor_if.sv
// proc_run_monitor_if: board controls, core status and verdict outputs of the run monitor.
interface proc_run_monitor_if #(
    parameter int FLAG_W = 5,
    parameter int CNT_W  = 11
);
    logic              start;
    logic              abort;
    logic              halt;
    logic [FLAG_W-1:0] flags;
    logic              core_rst;
    logic              running;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [CNT_W-1:0]  cycle_count;
    logic [FLAG_W-1:0] flags_snap;
    logic [FLAG_W-1:0] flags_seen;
    modport master (
        input  start, abort, halt, flags,
        output core_rst, running, done, pass, fail, timeout, cycle_count, flags_snap, flags_seen
    );
    modport slave (
        output start, abort, halt, flags,
        input  core_rst, running, done, pass, fail, timeout, cycle_count, flags_snap, flags_seen
    );
endinterface

// File: rtl/proc_run_monitor_sat_counter.sv
// sat_counter: up-counter with synchronous clear that stops at LIMIT instead of wrapping.
module sat_counter #(
    parameter int           W     = 4,
    parameter logic [W-1:0] LIMIT = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en && q != LIMIT)
            q <= q + 1'b1;
    end
endmodule

// File: rtl/proc_run_monitor.sv
// proc_run_monitor: sequences core reset, times the run, and latches a pass/fail/timeout verdict.
module proc_run_monitor
    import proc_mon_pkg::*;
#(
    parameter int                FLAG_W     = 5,
    parameter int                RST_HOLD   = 4,
    parameter int                TIMEOUT    = 1024,
    parameter logic [FLAG_W-1:0] PASS_MASK  = '1,
    parameter logic [FLAG_W-1:0] PASS_VALUE = '0
) (
    input logic                 clk,
    input logic                 rst,
    proc_run_monitor_if.master  bus
);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);
    localparam int HOLD_W = $clog2(RST_HOLD + 1);
    state_t            state, state_nx;
    verdict_t          verdict;
    logic [HOLD_W-1:0] hold;
    logic [CNT_W-1:0]  cnt;
    logic [FLAG_W-1:0] snap, seen;
    logic              enter_reset, hold_end, at_limit, match;
    assign enter_reset = bus.start && !bus.abort && (state == IDLE || state == DONE);
    assign hold_end    = hold == HOLD_W'(RST_HOLD - 1);
    assign at_limit    = cnt == CNT_W'(TIMEOUT - 1);
    assign match       = (snap & PASS_MASK) == (PASS_VALUE & PASS_MASK);
    sat_counter #(.W(HOLD_W), .LIMIT(HOLD_W'(RST_HOLD - 1))) u_hold (
        .clk(clk), .rst(rst), .clr(enter_reset), .en(state == RESET), .q(hold)
    );
    sat_counter #(.W(CNT_W), .LIMIT(CNT_W'(TIMEOUT - 1))) u_cycle (
        .clk(clk), .rst(rst), .clr(enter_reset), .en(state == RUN), .q(cnt)
    );
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.start ? RESET : IDLE;
            RESET:   state_nx = hold_end ? RUN : RESET;
            RUN:     state_nx = bus.halt ? CHECK : at_limit ? DONE : RUN;
            CHECK:   state_nx = DONE;
            DONE:    state_nx = bus.start ? RESET : DONE;
            default: state_nx = IDLE;
        endcase
        if (bus.abort)
            state_nx = IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            verdict <= V_NONE;
            snap    <= '0;
            seen    <= '0;
        end else begin
            state <= state_nx;
            if (bus.abort || enter_reset)
                verdict <= V_NONE;
            else if (state == RUN && !bus.halt && at_limit)
                verdict <= V_TIMEOUT;
            else if (state == CHECK)
                verdict <= match ? V_PASS : V_FAIL;
            // Abort keeps the flag history; only a fresh run clears it.
            if (enter_reset) begin
                snap <= '0;
                seen <= '0;
            end else if (state == RUN) begin
                seen <= seen | bus.flags;
                if (bus.halt && !bus.abort)
                    snap <= bus.flags;
            end
        end
    end
    assign bus.core_rst    = state != RUN;
    assign bus.running     = state == RUN;
    assign bus.done        = state == DONE;
    assign {bus.timeout, bus.fail, bus.pass} = verdict;
    assign bus.cycle_count = cnt;
    assign bus.flags_snap  = snap;
    assign bus.flags_seen  = seen;
endmodule

// File: tb/tb_proc_run_monitor.sv
// tb_proc_run_monitor: directed scenarios plus random traffic against a cycle-level run model.
module tb_proc_run_monitor;
    localparam int              FW   = 5;
    localparam int              RH   = 4;
    localparam int              TO   = 16;
    localparam int              CW   = $clog2(TO + 1);
    localparam logic [FW-1:0]   MASK = 5'b11111;
    localparam logic [FW-1:0]   VAL  = 5'b00001;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    proc_run_monitor_if #(.FLAG_W(FW), .CNT_W(CW)) bus ();
    proc_run_monitor #(
        .FLAG_W(FW), .RST_HOLD(RH), .TIMEOUT(TO), .PASS_MASK(MASK), .PASS_VALUE(VAL)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    int n_chk  = 0;
    int n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask
    // Model: phase 0 idle, 1 core held in reset, 2 running, 3 checking, 4 finished.
    int            ph      = 0;
    int            hold_n  = 0;
    int            m_cnt   = 0;
    int            old_cnt = 0;
    logic [FW-1:0] m_snap  = '0;
    logic [FW-1:0] m_seen  = '0;
    bit            m_p = 0, m_f = 0, m_t = 0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph = 0; hold_n = 0; m_cnt = 0; m_snap = '0; m_seen = '0;
            m_p = 0; m_f = 0; m_t = 0;
        end else begin
            old_cnt = m_cnt;
            if (ph == 2) begin
                m_seen |= bus.flags;
                if (m_cnt < TO - 1) m_cnt++;
            end
            if (bus.abort) begin
                ph = 0; m_p = 0; m_f = 0; m_t = 0;
            end else if ((ph == 0 || ph == 4) && bus.start) begin
                ph = 1; hold_n = 0; m_cnt = 0; m_snap = '0; m_seen = '0;
                m_p = 0; m_f = 0; m_t = 0;
            end else if (ph == 1) begin
                hold_n++;
                if (hold_n == RH) ph = 2;
            end else if (ph == 2) begin
                if (bus.halt) begin
                    m_snap = bus.flags; ph = 3;
                end else if (old_cnt == TO - 1) begin
                    m_t = 1; m_f = 1; ph = 4;
                end
            end else if (ph == 3) begin
                if ((m_snap & MASK) == (VAL & MASK)) m_p = 1; else m_f = 1;
                ph = 4;
            end
        end
    end
    always @(negedge clk) begin
        if (rst) begin
            chk("outputs",
                32'({bus.core_rst, bus.running, bus.done, bus.pass, bus.fail, bus.timeout,
                     bus.cycle_count, bus.flags_snap, bus.flags_seen}),
                32'({ph != 2, ph == 2, ph == 4, m_p, m_f, m_t, CW'(m_cnt), m_snap, m_seen}));
            if (bus.done) begin
                chk("one_verdict", 32'(bus.pass ^ bus.fail), 32'd1);
                chk("timeout_implies_fail", 32'(!bus.timeout || bus.fail), 32'd1);
            end
        end
    end
    task automatic start_run();
        int n;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("verdict_cleared", 32'({bus.pass, bus.fail, bus.timeout}), 32'd0);
        n = 0;
        while (!bus.running && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("start_to_run", 32'(n), 32'(RH));
    endtask
    task automatic halt_pulse();
        bus.halt = 1'b1;
        @(negedge clk);
        bus.halt = 1'b0;
        chk("check_not_done", 32'(bus.done), 32'd0);
        @(negedge clk);
    endtask
    initial begin
        int n;
        bus.start = 1'b0; bus.abort = 1'b0; bus.halt = 1'b0; bus.flags = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_after_reset", 32'({bus.core_rst, bus.running, bus.done, bus.pass, bus.fail,
            bus.timeout, bus.cycle_count, bus.flags_snap, bus.flags_seen}), 32'h100000);
        // pass
        bus.flags = 5'b00001;
        start_run();
        repeat (5) @(negedge clk);
        halt_pulse();
        chk("pass", 32'(bus.pass), 32'd1);
        chk("pass_fail_bit", 32'(bus.fail), 32'd0);
        chk("pass_cnt", 32'(bus.cycle_count), 32'd6);
        chk("pass_snap", 32'(bus.flags_snap), 32'h01);
        // fail with an earlier flag pulse, restarting from DONE
        bus.flags = 5'b00000;
        start_run();
        @(negedge clk); bus.flags = 5'b10000;
        @(negedge clk); bus.flags = 5'b00000;
        repeat (3) @(negedge clk);
        bus.flags = 5'b00101;
        halt_pulse();
        chk("fail", 32'({bus.pass, bus.fail}), 32'b01);
        chk("fail_seen", 32'(bus.flags_seen), 32'h15);
        chk("fail_snap", 32'(bus.flags_snap), 32'h05);
        // start pulsed during RUN is ignored
        bus.flags = 5'b00001;
        start_run();
        repeat (2) @(negedge clk);
        bus.start = 1'b1; @(negedge clk); bus.start = 1'b0;
        repeat (2) @(negedge clk);
        halt_pulse();
        chk("ignored_start_cnt", 32'(bus.cycle_count), 32'd6);
        chk("ignored_start_pass", 32'(bus.pass), 32'd1);
        // timeout
        bus.flags = 5'b00000;
        start_run();
        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_latency", 32'(n), 32'(TO));
        chk("timeout_bits", 32'({bus.timeout, bus.fail, bus.pass}), 32'b110);
        chk("timeout_cnt", 32'(bus.cycle_count), 32'd15);
        // halt on the timeout cycle wins
        bus.flags = 5'b00001;
        start_run();
        repeat (15) @(negedge clk);
        chk("collide_pre_cnt", 32'(bus.cycle_count), 32'd15);
        halt_pulse();
        chk("collide_bits", 32'({bus.timeout, bus.fail, bus.pass}), 32'b001);
        chk("collide_cnt", 32'(bus.cycle_count), 32'd15);
        // abort mid-run, then start together with abort
        start_run();
        repeat (2) @(negedge clk);
        bus.abort = 1'b1; @(negedge clk); bus.abort = 1'b0;
        chk("abort_state", 32'({bus.core_rst, bus.running, bus.done}), 32'b100);
        chk("abort_verdict", 32'({bus.pass, bus.fail, bus.timeout}), 32'd0);
        chk("abort_cnt", 32'(bus.cycle_count), 32'd3);
        bus.start = 1'b1; bus.abort = 1'b1; @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0;
        repeat (RH + 2) @(negedge clk);
        chk("abort_beats_start", 32'(bus.running), 32'd0);
        // asynchronous reset during a run
        start_run();
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("async_reset", 32'({bus.core_rst, bus.running, bus.cycle_count}), 32'h40);
        @(negedge clk);
        rst = 1'b1;
        // random traffic
        repeat (3000) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 7) == 0);
            bus.abort = ($urandom_range(0, 39) == 0);
            bus.halt  = ($urandom_range(0, 11) == 0);
            bus.flags = ($urandom_range(0, 1) == 0) ? 5'b00001 : FW'($urandom);
        end
        @(negedge clk);
        bus.start = 1'b0; bus.abort = 1'b0; bus.halt = 1'b0;
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
